// File: rtl/pop_result_fifo_pkg.sv
// Shared types, limits and helpers for the population-count result FIFO.
// Imported by the FIFO top and by anything that models its entries.
package pop_result_fifo_pkg;

    localparam int DEF_CNT_W = 6;
    localparam int unsigned MAX_COUNT = 32;

    typedef struct packed {
        logic [DEF_CNT_W-1:0] count;
        logic                 odd;
    } result_entry_t;

    // Increments value but holds at the all-ones pattern of the given width.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] maxVal;
        maxVal = 32'hFFFF_FFFF >> (32 - width);
        return (value == maxVal) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pop_fifo_mem.sv
// Register-array storage for the result FIFO.
// Single write port and an asynchronous read port, no reset on contents.
module pop_fifo_mem #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 7
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pop_result_fifo.sv
// Result FIFO behind the popcount/parity stage: first-word fall-through head,
// saturating statistics and sticky error flags with a synchronous clear.
module pop_result_fifo
    import pop_result_fifo_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 6,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [CNT_W-1:0]  in_count,
    input  logic              in_odd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_odd,
    output logic              full,
    output logic              empty,
    output logic [STAT_W-1:0] total_cnt,
    output logic [STAT_W-1:0] odd_cnt,
    output logic [STAT_W-1:0] drop_cnt,
    output logic              overflow,
    output logic              par_err,
    input  logic              clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [STAT_W-1:0] total_q, total_d;
    logic [STAT_W-1:0] odd_q, odd_d;
    logic [STAT_W-1:0] drop_q, drop_d;
    logic              overflow_q, overflow_d;
    logic              par_err_q, par_err_d;

    logic              doPush;
    logic              doPop;
    logic              doDrop;
    logic              badInput;
    logic [CNT_W:0]    rdData;

    assign empty     = (occ_q == '0);
    assign full      = (occ_q == OCC_W'(DEPTH));
    assign out_valid = !empty;

    assign doPop    = out_valid && out_ready;
    assign doPush   = in_valid && (!full || doPop);
    assign doDrop   = in_valid && full && !doPop;
    assign badInput = in_valid && ((in_odd != in_count[0]) || (32'(in_count) > MAX_COUNT));

    pop_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (CNT_W + 1)
    ) u_mem (
        .clk     (clk),
        .we_i    (doPush),
        .waddr_i (wr_ptr_q),
        .wdata_i ({in_count, in_odd}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdData)
    );

    // Head data is masked while empty so stale storage never leaks out.
    assign out_count = empty ? '0 : rdData[CNT_W:1];
    assign out_odd   = !empty && rdData[0];

    always_comb begin
        wr_ptr_d   = doPush ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = doPop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        occ_d      = occ_q;
        if (doPush && !doPop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (doPop && !doPush) begin
            occ_d = occ_q - OCC_W'(1);
        end

        total_d    = total_q;
        odd_d      = odd_q;
        drop_d     = drop_q;
        overflow_d = overflow_q;
        par_err_d  = par_err_q;
        // Clear wins over any increment or flag set in the same cycle.
        if (clr) begin
            total_d    = '0;
            odd_d      = '0;
            drop_d     = '0;
            overflow_d = 1'b0;
            par_err_d  = 1'b0;
        end else begin
            if (doPush) begin
                total_d = STAT_W'(sat_inc(32'(total_q), STAT_W));
            end
            if (doPush && in_odd) begin
                odd_d = STAT_W'(sat_inc(32'(odd_q), STAT_W));
            end
            if (doDrop) begin
                drop_d     = STAT_W'(sat_inc(32'(drop_q), STAT_W));
                overflow_d = 1'b1;
            end
            if (badInput) begin
                par_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            total_q    <= '0;
            odd_q      <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            total_q    <= total_d;
            odd_q      <= odd_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
            par_err_q  <= par_err_d;
        end
    end

    assign total_cnt = total_q;
    assign odd_cnt   = odd_q;
    assign drop_cnt  = drop_q;
    assign overflow  = overflow_q;
    assign par_err   = par_err_q;

endmodule

// File: tb/tb_pop_result_fifo.sv
// Scoreboard bench for pop_result_fifo: a queue model tracks stored entries
// and statistics, and every cycle the DUT state is compared against it.
module tb_pop_result_fifo;
    import pop_result_fifo_pkg::*;

    localparam int DEPTH  = 4;
    localparam int CNT_W  = 6;
    localparam int STAT_W = 4;
    localparam int SAT    = (1 << STAT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [CNT_W-1:0]  in_count;
    logic              in_odd;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic              out_odd;
    logic              full;
    logic              empty;
    logic [STAT_W-1:0] total_cnt;
    logic [STAT_W-1:0] odd_cnt;
    logic [STAT_W-1:0] drop_cnt;
    logic              overflow;
    logic              par_err;
    logic              clr;

    int numChecks = 0;
    int numFails  = 0;

    result_entry_t sb[$];
    int   modelTotal, modelOdd, modelDrop;
    logic modelOvf, modelPar;

    pop_result_fifo #(
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W),
        .STAT_W (STAT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_count  (in_count),
        .in_odd    (in_odd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_odd   (out_odd),
        .full      (full),
        .empty     (empty),
        .total_cnt (total_cnt),
        .odd_cnt   (odd_cnt),
        .drop_cnt  (drop_cnt),
        .overflow  (overflow),
        .par_err   (par_err),
        .clr       (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Compares every visible output against the model, including the head.
    task automatic checkState();
        checkOutput("outValid", 32'(out_valid), 32'(sb.size() != 0));
        checkOutput("empty",    32'(empty),     32'(sb.size() == 0));
        checkOutput("full",     32'(full),      32'(sb.size() == DEPTH));
        checkOutput("totalCnt", 32'(total_cnt), 32'(modelTotal));
        checkOutput("oddCnt",   32'(odd_cnt),   32'(modelOdd));
        checkOutput("dropCnt",  32'(drop_cnt),  32'(modelDrop));
        checkOutput("overflow", 32'(overflow),  32'(modelOvf));
        checkOutput("parErr",   32'(par_err),   32'(modelPar));
        if (sb.size() != 0) begin
            checkOutput("headCount", 32'(out_count), 32'(sb[0].count));
            checkOutput("headOdd",   32'(out_odd),   32'(sb[0].odd));
        end else begin
            checkOutput("maskCount", 32'(out_count), 32'd0);
            checkOutput("maskOdd",   32'(out_odd),   32'd0);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [CNT_W-1:0] c, input logic o,
                                 input logic r, input logic clear);
        logic doPop, doPush, doDrop, bad;
        in_valid  = v;
        in_count  = c;
        in_odd    = o;
        out_ready = r;
        clr       = clear;
        doPop  = (sb.size() != 0) && r;
        doPush = v && ((sb.size() != DEPTH) || doPop);
        doDrop = v && !doPush;
        bad    = v && ((o != c[0]) || (c > 6'd32));
        if (doPop) begin
            void'(sb.pop_front());
        end
        if (doPush) begin
            sb.push_back('{count: c, odd: o});
        end
        if (clear) begin
            modelTotal = 0;
            modelOdd   = 0;
            modelDrop  = 0;
            modelOvf   = 1'b0;
            modelPar   = 1'b0;
        end else begin
            if (doPush && modelTotal < SAT) modelTotal++;
            if (doPush && o && modelOdd < SAT) modelOdd++;
            if (doDrop && modelDrop < SAT) modelDrop++;
            if (doDrop) modelOvf = 1'b1;
            if (bad) modelPar = 1'b1;
        end
        @(posedge clk);
        #1;
        checkState();
    endtask

    task automatic applyReset(input int cycles);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_count  = '0;
        in_odd    = 1'b0;
        out_ready = 1'b0;
        clr       = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        sb.delete();
        modelTotal = 0;
        modelOdd   = 0;
        modelDrop  = 0;
        modelOvf   = 1'b0;
        modelPar   = 1'b0;
        checkState();
        rst_n = 1'b1;
    endtask

    task automatic drain(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        $display("[TB] starting pop_result_fifo bench");
        applyReset(2);

        // Ordered flow with downstream stalled, then released.
        applyStimulus(1'b1, 6'd5,  1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 6'd8,  1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 6'd32, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0,    1'b0, 1'b0, 1'b0);
        drain(4);

        // Fill past capacity: the fifth push is dropped.
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 6'd1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 6'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 6'd3, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 6'd4, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 6'd6, 1'b0, 1'b0, 1'b0);
        drain(5);

        // Full with a simultaneous pop accepts the push.
        applyStimulus(1'b1, 6'd10, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 6'd11, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 6'd12, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 6'd13, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 6'd14, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 6'd15, 1'b1, 1'b1, 1'b0);
        drain(5);

        // Parity errors still store the entry; clear beats a same-cycle push.
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 6'd7,  1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 6'd33, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 6'd9,  1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        drain(4);

        // Saturation while streaming, then reset with entries queued.
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            logic [CNT_W-1:0] c;
            c = CNT_W'(i % 33);
            applyStimulus(1'b1, c, c[0], 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 6'd21, 1'b1, 1'b0, 1'b0);
        checkOutput("satTotal", 32'(total_cnt), 32'(SAT));
        checkOutput("twoQueued", 32'(sb.size()), 32'd2);
        applyReset(1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
